// File: rtl/fan_ctrl_core.sv
// fan_ctrl_core: speed levels, temperature-driven auto mode, off-timer and
// emergency stop merged into one registered controller driving a ramped PWM.
module fan_ctrl_core #(
  parameter int LEVELS      = 3,
  parameter int PWM_BITS    = 8,
  parameter int RAMP_DIV    = 1000,
  parameter int TICK_DIV    = 125_000_000,
  parameter int TIMER_STEPS = 3,
  parameter int TIMER_UNIT  = 3600,
  parameter int TEMP_BASE   = 24,
  parameter int TEMP_STEP   = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_p,
  input  logic                                 speed_pe,
  input  logic                                 auto_pe,
  input  logic                                 timer_pe,
  input  logic [7:0]                           temp,
  input  logic                                 temp_valid,
  input  logic                                 emcy,
  input  logic                                 emcy_en,
  output logic                                 pwm,
  output logic [PWM_BITS-1:0]                  duty,
  output logic [$clog2(LEVELS+1)-1:0]          level,
  output logic                                 auto_mode,
  output logic [1:0]                           state,
  output logic [$clog2(TIMER_STEPS+1)-1:0]     timer_step,
  output logic [15:0]                          timer_sec,
  output logic                                 timeout
);

  localparam int LW       = $clog2(LEVELS + 1);
  localparam int TW       = $clog2(TIMER_STEPS + 1);
  localparam int DUTY_MAX = (1 << PWM_BITS) - 1;
  localparam int RW       = $clog2(RAMP_DIV + 1);
  localparam int SW       = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EMCY = 2'd2
  } state_t;

  state_t                state_q;
  logic [7:0]            temp_q;
  logic [7:0]            temp_eff;
  logic                  emcy_act;
  logic [LW-1:0]         auto_lvl;
  logic [SW-1:0]         sec_cnt;
  logic                  timer_run;
  logic                  tick;
  logic                  expire;
  logic [RW-1:0]         ramp_cnt;
  logic [PWM_BITS-1:0]   target_q;
  logic [PWM_BITS-1:0]   target_n;
  logic [PWM_BITS-1:0]   pwm_cnt;

  logic [LW-1:0]         level_n;
  logic                  auto_n;
  logic [TW-1:0]         step_n;
  logic [15:0]           sec_n;
  logic                  load;
  state_t                state_n;

  // Auto level: 0 below the base temperature, then one level per TEMP_STEP degrees.
  function automatic logic [LW-1:0] auto_level_of(input logic [7:0] t);
    int lv;
    if (int'(t) < TEMP_BASE) begin
      lv = 0;
    end else begin
      lv = 1 + (int'(t) - TEMP_BASE) / TEMP_STEP;
      if (lv > LEVELS) lv = LEVELS;
    end
    return LW'(lv);
  endfunction

  // Target duty scales linearly so the top level reaches full duty exactly.
  function automatic logic [PWM_BITS-1:0] target_of(input logic [LW-1:0] lv);
    longint v;
    v = (longint'(lv) * longint'(DUTY_MAX)) / longint'(LEVELS);
    return PWM_BITS'(v);
  endfunction

  // Timer preset in seconds, saturated to the 16-bit display range.
  function automatic logic [15:0] timer_load(input logic [TW-1:0] s);
    longint v;
    v = longint'(s) * longint'(TIMER_UNIT);
    if (v > 65535) v = 65535;
    return 16'(v);
  endfunction

  assign emcy_act  = emcy & emcy_en;
  assign temp_eff  = temp_valid ? temp : temp_q;
  assign auto_lvl  = auto_level_of(temp_eff);
  assign timer_run = (state_q == ST_RUN) && !emcy_act && (timer_step != '0);
  assign tick      = timer_run && (sec_cnt == SW'(TICK_DIV - 1));
  assign expire    = tick && (timer_sec == 16'd1);
  assign target_n  = target_of(level);
  assign state     = state_q;

  // Latch the temperature only when the sensor front end qualifies it.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) temp_q <= 8'd0;
    else if (temp_valid) temp_q <= temp;
  end

  // Next-state decode for buttons and timer; the higher-priority pulse wins.
  always_comb begin
    level_n = level;
    auto_n  = auto_mode;
    step_n  = timer_step;
    sec_n   = timer_sec;
    load    = 1'b0;
    state_n = state_t'(state_q);
    if (!emcy_act && !expire) begin
      if (speed_pe) begin
        auto_n  = 1'b0;
        level_n = (level == LW'(LEVELS)) ? '0 : level + LW'(1);
      end else if (auto_pe) begin
        auto_n = !auto_mode;
        if (!auto_mode) level_n = auto_lvl;
      end else begin
        if (auto_mode) level_n = auto_lvl;
        if (timer_pe && (state_q == ST_RUN)) begin
          step_n = (timer_step == TW'(TIMER_STEPS)) ? '0 : timer_step + TW'(1);
          sec_n  = timer_load(step_n);
          load   = 1'b1;
        end
      end
      if (tick && !load && (timer_sec != 16'd0)) sec_n = timer_sec - 16'd1;
      if ((level_n == '0) && !auto_n) begin
        step_n  = '0;
        sec_n   = 16'd0;
        state_n = ST_IDLE;
      end else begin
        state_n = ST_RUN;
      end
    end
  end

  // Main state machine: emergency freezes everything, expiry shuts the fan off.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q    <= ST_IDLE;
      level      <= '0;
      auto_mode  <= 1'b0;
      timer_step <= '0;
      timer_sec  <= 16'd0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (emcy_act) begin
        state_q <= ST_EMCY;
      end else if (expire) begin
        timeout    <= 1'b1;
        level      <= '0;
        auto_mode  <= 1'b0;
        timer_step <= '0;
        timer_sec  <= 16'd0;
        state_q    <= ST_IDLE;
      end else begin
        level      <= level_n;
        auto_mode  <= auto_n;
        timer_step <= step_n;
        timer_sec  <= sec_n;
        state_q    <= state_n;
      end
    end
  end

  // One-second prescaler: restarts on each timer load, holds while not counting.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sec_cnt <= '0;
    end else if (load) begin
      sec_cnt <= '0;
    end else if (timer_run) begin
      sec_cnt <= tick ? '0 : sec_cnt + SW'(1);
    end
  end

  // Soft-start ramp: one duty step per RAMP_DIV clocks, hard zero in emergency.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      target_q <= '0;
      duty     <= '0;
      ramp_cnt <= '0;
    end else begin
      target_q <= target_n;
      if (emcy_act) begin
        duty     <= '0;
        ramp_cnt <= '0;
      end else if (target_n != target_q) begin
        ramp_cnt <= '0;
      end else if (ramp_cnt == RW'(RAMP_DIV - 1)) begin
        ramp_cnt <= '0;
        if (duty < target_q) duty <= duty + PWM_BITS'(1);
        else if (duty > target_q) duty <= duty - PWM_BITS'(1);
      end else begin
        ramp_cnt <= ramp_cnt + RW'(1);
      end
    end
  end

  // Free-running PWM period of DUTY_MAX clocks with a registered compare output.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      pwm_cnt <= '0;
      pwm     <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == PWM_BITS'(DUTY_MAX - 1)) ? '0 : pwm_cnt + PWM_BITS'(1);
      pwm     <= (pwm_cnt < duty);
    end
  end

endmodule

// File: tb/tb_fan_ctrl_core.sv
// tb_fan_ctrl_core: directed vectors with hand-computed expectations.
module tb_fan_ctrl_core;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        speed_pe, auto_pe, timer_pe;
  logic [7:0]  temp;
  logic        temp_valid;
  logic        emcy, emcy_en;
  logic        pwm;
  logic [3:0]  duty;
  logic [1:0]  level;
  logic        auto_mode;
  logic [1:0]  state;
  logic [1:0]  timer_step;
  logic [15:0] timer_sec;
  logic        timeout;

  int checkCount   = 0;
  int passCount    = 0;
  int timeoutCount = 0;
  int tcBefore;
  int highCount;

  fan_ctrl_core #(
    .LEVELS(3), .PWM_BITS(4), .RAMP_DIV(2), .TICK_DIV(10),
    .TIMER_STEPS(3), .TIMER_UNIT(5), .TEMP_BASE(24), .TEMP_STEP(2)
  ) dut (
    .clk(clk), .reset_p(reset_p), .speed_pe(speed_pe), .auto_pe(auto_pe),
    .timer_pe(timer_pe), .temp(temp), .temp_valid(temp_valid), .emcy(emcy),
    .emcy_en(emcy_en), .pwm(pwm), .duty(duty), .level(level),
    .auto_mode(auto_mode), .state(state), .timer_step(timer_step),
    .timer_sec(timer_sec), .timeout(timeout)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Count timeout pulses, sampled away from the active edge
  always @(negedge clk) if (timeout) timeoutCount++;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 0 = speed, 1 = auto, 2 = timer; one-cycle pulse sampled by one posedge
  task automatic applyStimulus(input int which);
    case (which)
      0: speed_pe = 1'b1;
      1: auto_pe  = 1'b1;
      default: timer_pe = 1'b1;
    endcase
    @(negedge clk);
    speed_pe = 1'b0;
    auto_pe  = 1'b0;
    timer_pe = 1'b0;
  endtask

  task automatic pulseTemp(input logic [7:0] t);
    temp = t;
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
  endtask

  task automatic countPwmHigh(output int n);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (pwm) n++;
    end
  endtask

  initial begin
    reset_p = 1'b1; speed_pe = 1'b0; auto_pe = 1'b0; timer_pe = 1'b0;
    temp = 8'd0; temp_valid = 1'b0; emcy = 1'b0; emcy_en = 1'b0;
    waitCycles(3);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_duty", duty, 0);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_pwm", pwm, 0);
    checkOutput("rst_auto", auto_mode, 0);
    checkOutput("rst_step", timer_step, 0);
    checkOutput("rst_sec", timer_sec, 0);
    checkOutput("rst_timeout", timeout, 0);
    reset_p = 1'b0;
    waitCycles(2);

    // Manual speed cycling and ramp timing
    applyStimulus(0);
    checkOutput("man_level1", level, 1);
    checkOutput("man_state_run", state, 1);
    waitCycles(10);
    checkOutput("ramp_before_end", duty, 4);
    waitCycles(1);
    checkOutput("ramp_end", duty, 5);
    countPwmHigh(highCount);
    checkOutput("pwm_high_l1", highCount, 5);
    applyStimulus(0);
    checkOutput("man_level2", level, 2);
    waitCycles(30);
    checkOutput("duty_l2", duty, 10);
    applyStimulus(0);
    checkOutput("man_level3", level, 3);
    waitCycles(30);
    checkOutput("duty_l3", duty, 15);
    countPwmHigh(highCount);
    checkOutput("pwm_high_full", highCount, 15);
    applyStimulus(0);
    checkOutput("man_level0", level, 0);
    checkOutput("man_state_idle", state, 0);
    waitCycles(40);
    checkOutput("duty_off", duty, 0);

    // Auto mode from temperature
    applyStimulus(1);
    checkOutput("auto_on", auto_mode, 1);
    checkOutput("auto_state", state, 1);
    pulseTemp(8'd23);
    checkOutput("auto_t23", level, 0);
    pulseTemp(8'd24);
    checkOutput("auto_t24", level, 1);
    pulseTemp(8'd27);
    checkOutput("auto_t27", level, 2);
    pulseTemp(8'd40);
    checkOutput("auto_t40", level, 3);
    pulseTemp(8'd27);
    checkOutput("auto_t27b", level, 2);
    applyStimulus(0);
    checkOutput("auto_speed_clr", auto_mode, 0);
    checkOutput("auto_speed_lvl", level, 3);
    pulseTemp(8'd23);
    checkOutput("manual_ignores_temp", level, 3);
    applyStimulus(0);
    checkOutput("auto_exit_idle", state, 0);
    waitCycles(60);

    // Timer countdown and expiry
    applyStimulus(0);
    applyStimulus(2);
    checkOutput("tmr_step1", timer_step, 1);
    checkOutput("tmr_sec5", timer_sec, 5);
    applyStimulus(2);
    checkOutput("tmr_step2", timer_step, 2);
    checkOutput("tmr_sec10", timer_sec, 10);
    tcBefore = timeoutCount;
    waitCycles(50);
    checkOutput("tmr_mid", timer_sec, 5);
    waitCycles(49);
    checkOutput("tmr_last_sec", timer_sec, 1);
    checkOutput("tmr_no_early_to", timeout, 0);
    waitCycles(1);
    checkOutput("tmr_timeout", timeout, 1);
    checkOutput("tmr_to_level", level, 0);
    checkOutput("tmr_to_state", state, 0);
    checkOutput("tmr_to_step", timer_step, 0);
    waitCycles(1);
    checkOutput("tmr_to_pulse1", timeout, 0);
    checkOutput("tmr_to_count", timeoutCount - tcBefore, 1);

    // Emergency stop with frozen timer
    applyStimulus(0);
    applyStimulus(0);
    waitCycles(40);
    checkOutput("emcy_pre_duty", duty, 10);
    applyStimulus(2);
    waitCycles(12);
    checkOutput("emcy_pre_sec", timer_sec, 4);
    emcy_en = 1'b1;
    emcy = 1'b1;
    waitCycles(1);
    checkOutput("emcy_state", state, 2);
    checkOutput("emcy_duty0", duty, 0);
    applyStimulus(0);
    checkOutput("emcy_speed_ign", level, 2);
    applyStimulus(2);
    checkOutput("emcy_timer_ign", timer_step, 1);
    waitCycles(30);
    checkOutput("emcy_sec_frozen", timer_sec, 4);
    checkOutput("emcy_duty_hold", duty, 0);
    emcy = 1'b0;
    waitCycles(1);
    checkOutput("emcy_release", state, 1);
    waitCycles(7);
    checkOutput("emcy_resume_pre", timer_sec, 4);
    waitCycles(1);
    checkOutput("emcy_resume_tick", timer_sec, 3);
    waitCycles(10);
    checkOutput("emcy_ramp9", duty, 9);
    waitCycles(1);
    checkOutput("emcy_ramp10", duty, 10);

    // Emergency request with enable low has no effect
    emcy_en = 1'b0;
    emcy = 1'b1;
    waitCycles(2);
    checkOutput("emcy_dis_state", state, 1);
    checkOutput("emcy_dis_duty", duty, 10);
    emcy = 1'b0;

    // Back to IDLE by button disarms the timer; timer ignored in IDLE
    applyStimulus(0);
    applyStimulus(0);
    checkOutput("idle_state", state, 0);
    checkOutput("idle_disarm_step", timer_step, 0);
    checkOutput("idle_disarm_sec", timer_sec, 0);
    applyStimulus(2);
    checkOutput("idle_timer_ign", timer_step, 0);

    // Asynchronous reset mid-ramp and mid-countdown
    applyStimulus(0);
    applyStimulus(2);
    waitCycles(7);
    tcBefore = timeoutCount;
    #2 reset_p = 1'b1;
    #1;
    checkOutput("arst_level", level, 0);
    checkOutput("arst_duty", duty, 0);
    checkOutput("arst_state", state, 0);
    checkOutput("arst_step", timer_step, 0);
    checkOutput("arst_sec", timer_sec, 0);
    checkOutput("arst_pwm", pwm, 0);
    waitCycles(60);
    reset_p = 1'b0;
    waitCycles(5);
    checkOutput("arst_no_timeout", timeoutCount - tcBefore, 0);
    checkOutput("arst_duty_after", duty, 0);

    // Same-cycle speed and auto: speed wins, auto dropped
    speed_pe = 1'b1;
    auto_pe = 1'b1;
    @(negedge clk);
    speed_pe = 1'b0;
    auto_pe = 1'b0;
    checkOutput("prio_level", level, 1);
    checkOutput("prio_auto", auto_mode, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
